stim_sequencer: RTL
===================

# stim_sequencer

Synthesizable stimulus sequencer that replaces the free-running program-counter loop in generated concolic benches. It fetches instruction words from a synchronous-read stimulus RAM and drives them onto the DUT input bus (`stim`, which carries the observation bit and input bits) at one word per cycle. It also supports DUT back-pressure, timed waits, restarts, halting and a step timeout. It sits between the stimulus RAM (loaded from `data.mem`) and the DUT top instance.

## Interface
- `DATA_W`, 2, payload/stimulus width (`{__obs, in}` for a 1-input DUT)
- `DEPTH`, 11, stimulus RAM depth in words
- `ADDR_W`, 4, RAM address width; must satisfy 2^ADDR_W ≥ DEPTH
- `MAX_STEPS`, 10, step limit before forced stop (only with `STIM_TIMEOUT_EN`)

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a run from address 0; ignored unless in IDLE or DONE
- `stop`  in  1  abort; next state is DONE
- `mem_addr`  out  ADDR_W  RAM read address (combinational from state)
- `mem_rdata`  in  DATA_W+2  word at the address issued the previous cycle; layout `{op[1:0], payload[DATA_W-1:0]}`
- `dut_ready`  in  1  DUT accepts `stim` this cycle; low means stall
- `stim`  out  DATA_W  registered stimulus to the DUT
- `stim_valid`  out  1  `stim` updated by a DRIVE this cycle
- `pc`  out  32  index of the word currently being executed
- `step_cnt`  out  32  number of DRIVE words consumed this run
- `busy`  out  1  high in FETCH, RUN or WAIT
- `done`  out  1  high in DONE
- `timeout`  out  1  run ended by the step limit

## Operation
- States: IDLE, FETCH, RUN, WAIT, DONE. Reset enters IDLE.
- IDLE/DONE → FETCH on `start`. Entering FETCH clears `pc`, `step_cnt` and `timeout`. FETCH drives `mem_addr=0` for one cycle, then goes to RUN.
- In RUN, `mem_rdata` is the word at `pc`. Opcodes:
  - 00 DRIVE: if `dut_ready`, `stim<=payload`, `stim_valid<=1`, `step_cnt++`, `pc++`, `mem_addr=pc+1`. If `dut_ready` is low, hold everything and drive `mem_addr=pc`.
  - 01 WAIT: load `wait_cnt=payload` and go to WAIT. Stay for payload+1 cycles in total, holding `stim`, with `mem_addr=pc+1`. On exit, `pc++` and return to RUN.
  - 10 RESTART: `pc<=0`, `mem_addr=0`. Takes one bubble cycle through FETCH.
  - 11 HALT: go to DONE; `pc` holds.
- End of program: consuming the word at `DEPTH-1` sets `pc=DEPTH` and goes to DONE. No wrap.
- `stop` has priority over every opcode and over `start` in the same cycle.
- `stim` keeps its last value in IDLE and DONE. `stim_valid` is 0 outside DRIVE cycles.
- Widths: `pc` and `step_cnt` wrap modulo 2^32. `mem_addr` is `pc[ADDR_W-1:0]`.

## Timing
- Reset values: `stim=0`, `stim_valid=0`, `pc=0`, `step_cnt=0`, `busy=0`, `done=0`, `timeout=0`. `mem_addr=0` in IDLE.
- Latency: the first `stim_valid` comes 2 cycles after the `start` edge (FETCH, then RUN).
- Throughput: one DRIVE per cycle while `dut_ready` is high.
- A stall cycle re-issues `mem_addr=pc`, so the RAM returns the same word on the next cycle.
- Reset asserted mid-run returns to IDLE immediately, with all outputs at their reset values. No instruction is partially executed.
- `start` and HALT in the same cycle: HALT wins, because `start` is ignored in RUN.

## Configuration
- `STIM_TIMEOUT_EN` defined: when a DRIVE makes `step_cnt==MAX_STEPS`, the next state is DONE with `timeout=1`. The limit is evaluated after that DRIVE's stimulus is applied.
- `STIM_TIMEOUT_EN` undefined: there is no step limit, `timeout` is tied to 0, and `MAX_STEPS` is unused.

## Test plan
- RAM = DRIVE 1, DRIVE 2, DRIVE 3, HALT; pulse `start` → `stim` = 1, 2, 3 on cycles 2, 3, 4 after `start`; `done=1` on cycle 5; `step_cnt=3`; `pc=3`.
- DRIVE 1, then `dut_ready` low for 3 cycles, then DRIVE 2 → `stim` holds 1 and `mem_addr` holds 1 during the stall; 2 appears the cycle after `dut_ready` rises.
- WAIT payload=2 between DRIVE 1 and DRIVE 3 → `stim` stays 1 for 3 extra cycles; `stim_valid` is low during them; then `stim=3`.
- All 11 words DRIVE with `STIM_TIMEOUT_EN` and `MAX_STEPS=10` → 10 drives, then DONE with `timeout=1` and `pc=10`. Without the macro → 11 drives, DONE with `pc=11` and `timeout=0`.
- Reset pulled low while in RUN after 2 drives → all outputs return to 0 in the same cycle; a later `start` replays from address 0.
- RESTART at word 2 with `stop` pulsed after 6 drives → sequence is 0, 1, 0, 1, 0, 1; then DONE; `step_cnt=6`.

Source files
------------

// File: rtl/stim_sequencer.sv
// Stimulus sequencer: executes {op, payload} words from a synchronous-read stimulus RAM
// and drives payloads onto the DUT input bus. Define STIM_TIMEOUT_EN to enable the MAX_STEPS limit.
module stim_sequencer #(
    parameter int DATA_W    = 2,
    parameter int DEPTH     = 11,
    parameter int ADDR_W    = 4,
    parameter int MAX_STEPS = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W+1:0] mem_rdata,
    input  logic              dut_ready,
    output logic [DATA_W-1:0] stim,
    output logic              stim_valid,
    output logic [31:0]       pc,
    output logic [31:0]       step_cnt,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_RUN   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [1:0]        OP_DRIVE   = 2'd0;
    localparam logic [1:0]        OP_WAIT    = 2'd1;
    localparam logic [1:0]        OP_RESTART = 2'd2;
    localparam logic [1:0]        OP_HALT    = 2'd3;
    localparam logic [31:0]       LAST_PC    = 32'(DEPTH - 1);
    localparam logic [DATA_W-1:0] WAIT_ONE   = DATA_W'(1'b1);
    localparam logic [DATA_W-1:0] WAIT_ZERO  = {DATA_W{1'b0}};
`ifdef STIM_TIMEOUT_EN
    localparam logic [31:0]       STEP_LIMIT = 32'(MAX_STEPS);
`endif

    state_e              state_q, state_d;
    logic [31:0]         pc_q, pc_d;
    logic [31:0]         step_cnt_q, step_cnt_d;
    logic [DATA_W-1:0]   stim_q, stim_d;
    logic                stim_valid_q, stim_valid_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   mem_addr_s;
    logic [1:0]          op_s;
    logic [DATA_W-1:0]   payload_s;
    logic [31:0]         pc_inc_s;
    logic [31:0]         step_inc_s;
    logic                last_word_s;

    assign op_s        = mem_rdata[DATA_W+1:DATA_W];
    assign payload_s   = mem_rdata[DATA_W-1:0];
    assign pc_inc_s    = pc_q + 32'd1;
    assign step_inc_s  = step_cnt_q + 32'd1;
    assign last_word_s = (pc_q == LAST_PC);

    // Next-state, datapath updates and RAM address selection.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        step_cnt_d   = step_cnt_q;
        stim_d       = stim_q;
        stim_valid_d = 1'b0;
        timeout_d    = timeout_q;
        wait_cnt_d   = wait_cnt_q;
        mem_addr_s   = pc_q[ADDR_W-1:0];

        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_IDLE) begin
                    mem_addr_s = {ADDR_W{1'b0}};
                end else begin
                    mem_addr_s = pc_q[ADDR_W-1:0];
                end
                if (stop) begin
                    state_d = S_DONE;
                end else if (start) begin
                    state_d    = S_FETCH;
                    pc_d       = 32'd0;
                    step_cnt_d = 32'd0;
                    timeout_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            S_FETCH: begin
                mem_addr_s = {ADDR_W{1'b0}};
                if (stop) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    state_d = S_DONE;
                end else begin
                    case (op_s)
                        OP_DRIVE: begin
                            if (dut_ready) begin
                                stim_d       = payload_s;
                                stim_valid_d = 1'b1;
                                step_cnt_d   = step_inc_s;
                                pc_d         = pc_inc_s;
                                mem_addr_s   = pc_inc_s[ADDR_W-1:0];
                                if (last_word_s) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_RUN;
                                end
`ifdef STIM_TIMEOUT_EN
                                // The limit is judged after this drive has been applied.
                                if (step_inc_s == STEP_LIMIT) begin
                                    state_d   = S_DONE;
                                    timeout_d = 1'b1;
                                end else begin
                                    timeout_d = timeout_q;
                                end
`endif
                            end else begin
                                mem_addr_s = pc_q[ADDR_W-1:0];
                            end
                        end
                        OP_WAIT: begin
                            // The decode cycle is the first of payload+1 wait cycles.
                            mem_addr_s = pc_inc_s[ADDR_W-1:0];
                            if (payload_s == WAIT_ZERO) begin
                                pc_d = pc_inc_s;
                                if (last_word_s) begin
                                    state_d = S_DONE;
                                end else begin
                                    state_d = S_RUN;
                                end
                            end else begin
                                wait_cnt_d = payload_s;
                                state_d    = S_WAIT;
                            end
                        end
                        OP_RESTART: begin
                            pc_d       = 32'd0;
                            mem_addr_s = {ADDR_W{1'b0}};
                            state_d    = S_FETCH;
                        end
                        OP_HALT: begin
                            state_d = S_DONE;
                        end
                        default: begin
                            state_d = S_DONE;
                        end
                    endcase
                end
            end

            S_WAIT: begin
                mem_addr_s = pc_inc_s[ADDR_W-1:0];
                if (stop) begin
                    state_d = S_DONE;
                end else if (wait_cnt_q == WAIT_ONE) begin
                    pc_d = pc_inc_s;
                    if (last_word_s) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_RUN) || (state_d == S_WAIT);
        done_d = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            pc_q         <= 32'd0;
            step_cnt_q   <= 32'd0;
            stim_q       <= {DATA_W{1'b0}};
            stim_valid_q <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            wait_cnt_q   <= {DATA_W{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            step_cnt_q   <= step_cnt_d;
            stim_q       <= stim_d;
            stim_valid_q <= stim_valid_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign mem_addr   = mem_addr_s;
    assign stim       = stim_q;
    assign stim_valid = stim_valid_q;
    assign pc         = pc_q;
    assign step_cnt   = step_cnt_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign timeout    = timeout_q;

endmodule
